conditional_arbiter: RTL and testbench
======================================

# conditional_arbiter

Two-requester arbiter and output register for the mixed-signedness select datapath. It shares one signed W-bit output channel between an unsigned source (U) and a signed source (S). U data is narrowed to W-1 bits and zero-extended into the signed result; S data passes through unchanged. Each transfer uses valid/ready handshakes, simultaneous requests are resolved round-robin, and per-source grant counts are kept for coverage sampling.

## Interface
Parameters:
- W, 4, data width of both sources and the output; legal range 2..16.
- CNT_W, 8, width of each grant counter.

Ports:
- clk  in  1  sole clock; all logic updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- u_valid  in  1  U source has data.
- u_data  in  W  U payload, unsigned.
- u_ready  out  1  U beat accepted this cycle when u_valid & u_ready.
- s_valid  in  1  S source has data.
- s_data  in  W  S payload, signed.
- s_ready  out  1  S beat accepted this cycle when s_valid & s_ready.
- out_valid  out  1  output register holds a result.
- out_data  out  W  signed result.
- out_src  out  1  source of the held result: 0 = U, 1 = S.
- out_trunc  out  1  held U result lost its MSB (u_data[W-1] was 1). Always 0 for S results.
- out_ready  in  1  consumer accepts the result.
- u_grants  out  CNT_W  saturating count of U beats accepted.
- s_grants  out  CNT_W  saturating count of S beats accepted.

## Operation
State machine, 2 states:
- EMPTY: out_valid=0.
- FULL: out_valid=1.

Transitions:
- EMPTY goes to FULL on any accept.
- FULL stays FULL when out_ready and an accept occur in the same cycle (back-to-back).
- FULL goes to EMPTY when out_ready is high and there is no accept.
- FULL holds its contents while out_ready is low.

Load rule:
- load_en = (state==EMPTY) | out_ready.

Grant rule:
- If only one source is valid, that source is granted.
- If both are valid, grant the source not named by last_src.
- last_src updates to the granted source on every accept.

Ready rule:
- u_ready = load_en & grant_u; s_ready = load_en & grant_s.
- Both readys are combinational from the valids, state and last_src.
- At most one ready is high per cycle.
- A ready may be high only while its valid is high.

Conversion:
- U: out_data = {1'b0, u_data[W-2:0]}, out_trunc = u_data[W-1].
  - The result is always non-negative.
- S: out_data = s_data, out_trunc = 0.
- No sign extension or arithmetic is performed. The width is W throughout.

Counters:
- Each counter increments by 1 on an accept from its source.
- Each counter holds at 2^CNT_W-1 (saturates, never wraps).

## Timing
Reset values:
- state=EMPTY, out_valid=0, out_data=0, out_src=0, out_trunc=0.
- u_grants=0, s_grants=0.
- last_src=1, so U wins the first contention.

Reset behaviour:
- Reset applies only on a clock edge with rst_n=0.
- Reset mid-transfer discards the held result.
- While rst_n=0, u_ready and s_ready must be 0.

Latency and throughput:
- An accepted beat appears on out_data in the next cycle, with out_valid=1.
- Throughput is 1 beat/cycle when out_ready stays high.

Hold rule:
- While out_valid=1 and out_ready=0, out_data, out_src and out_trunc are stable.

Simultaneous events:
- Drain and accept in the same cycle: the new result replaces the old one with no bubble.
- Both sources valid for N cycles with out_ready=1: grants alternate U,S,U,S...

## Structure
Package conditional_pkg holds:
- src_e enum (SRC_U=1'b0, SRC_S=1'b1).
- state_e enum (EMPTY, FULL).
- Default constants W_DEF=4 and CNT_W_DEF=8.

Sub-module:
- One natural sub-module: sat_counter (CNT_W, inc) → count.
- It is instantiated twice, once per grant counter.

## Test plan
- Reset with rst_n=0 for 2 cycles while u_valid=s_valid=1 → both readys 0, out_valid=0, both counters 0. After release, U is granted first.
- U only, u_data=4'b1011, out_ready=1 → next cycle out_data=4'sb0011 (+3), out_src=0, out_trunc=1, u_grants=1.
- S only, s_data=4'sb1011 (−5) → out_data=−5, out_src=1, out_trunc=0.
- Both valid for 6 cycles with out_ready=1 → grant order U,S,U,S,U,S; u_grants=s_grants=3; no idle cycle on out_valid.
- out_ready=0 for 3 cycles while FULL with both sources valid → both readys 0, out_data stable. On out_ready=1, a new beat loads the same cycle.
- With CNT_W=2, 5 U accepts → u_grants saturates at 3. Assert rst_n=0 while FULL → out_valid=0 on the next edge.

Source files
------------

// File: rtl/conditional_pkg.sv
// Shared types and defaults for the two-source signed/unsigned output arbiter.
package conditional_pkg;

  typedef enum logic {
    SRC_U = 1'b0,
    SRC_S = 1'b1
  } src_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int W_DEF     = 4;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/conditional_arbiter.sv
// Round-robin arbiter merging an unsigned (U) and a signed (S) source into one
// registered signed output channel, with saturating per-source grant counters.
module conditional_arbiter
  import conditional_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                u_valid,
  input  logic [W-1:0]        u_data,
  output logic                u_ready,
  input  logic                s_valid,
  input  logic signed [W-1:0] s_data,
  output logic                s_ready,
  output logic                out_valid,
  output logic signed [W-1:0] out_data,
  output logic                out_src,
  output logic                out_trunc,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    u_grants,
  output logic [CNT_W-1:0]    s_grants
);

  state_e              state_q, state_d;
  src_e                last_src_q, last_src_d;
  logic signed [W-1:0] data_q, data_d;
  src_e                src_q, src_d;
  logic                trunc_q, trunc_d;

  logic load_en, grant_u, grant_s, u_acc, s_acc;

  always_comb begin
    load_en = (state_q == EMPTY) | out_ready;
    // On contention the source that did not win last time gets the slot.
    grant_u = u_valid & (~s_valid | (last_src_q == SRC_S));
    grant_s = s_valid & (~u_valid | (last_src_q == SRC_U));
    // Readys are forced low while reset is asserted so no beat is consumed.
    u_ready = rst_n & load_en & grant_u;
    s_ready = rst_n & load_en & grant_s;
    u_acc   = u_valid & u_ready;
    s_acc   = s_valid & s_ready;
  end

  always_comb begin
    state_d    = state_q;
    last_src_d = last_src_q;
    data_d     = data_q;
    src_d      = src_q;
    trunc_d    = trunc_q;
    unique case (state_q)
      EMPTY: if (u_acc || s_acc) state_d = FULL;
      FULL: begin
        if (u_acc || s_acc) state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (u_acc) begin
      data_d     = signed'({1'b0, u_data[W-2:0]});
      src_d      = SRC_U;
      trunc_d    = u_data[W-1];
      last_src_d = SRC_U;
    end else if (s_acc) begin
      data_d     = s_data;
      src_d      = SRC_S;
      trunc_d    = 1'b0;
      last_src_d = SRC_S;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      last_src_q <= SRC_S;
      data_q     <= '0;
      src_q      <= SRC_U;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_src_q <= last_src_d;
      data_q     <= data_d;
      src_q      <= src_d;
      trunc_q    <= trunc_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_trunc = trunc_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_u (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (u_acc),
    .count (u_grants)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_s (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (s_acc),
    .count (s_grants)
  );

endmodule

// File: tb/tb_conditional_arbiter.sv
// Directed vector bench: a W=4/CNT_W=8 instance plus a CNT_W=2 instance on the
// same stimulus to exercise counter saturation.
module tb_conditional_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, u_valid, s_valid, out_ready;
  logic [3:0] u_data;
  logic signed [3:0] s_data;

  logic u_ready, s_ready, out_valid, out_src, out_trunc;
  logic signed [3:0] out_data;
  logic [7:0] u_grants, s_grants;

  logic u_ready2, s_ready2, out_valid2, out_src2, out_trunc2;
  logic signed [3:0] out_data2;
  logic [1:0] u_grants2, s_grants2;

  logic [3:0] od_u;
  assign od_u = out_data;

  conditional_arbiter #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .u_valid(u_valid), .u_data(u_data), .u_ready(u_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_trunc(out_trunc), .out_ready(out_ready),
    .u_grants(u_grants), .s_grants(s_grants)
  );

  conditional_arbiter #(.W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .u_valid(u_valid), .u_data(u_data), .u_ready(u_ready2),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_src(out_src2),
    .out_trunc(out_trunc2), .out_ready(out_ready),
    .u_grants(u_grants2), .s_grants(s_grants2)
  );

  typedef struct {
    logic       rst, uv, sv, ordy;
    logic [3:0] ud, sd;
    logic       ur, sr;
    logic       ov;
    logic [3:0] od;
    logic       osrc, otr, cd;
    int         ug, sg, ug2, sg2;
  } vec_t;

  vec_t vecs[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic uv, input logic [3:0] ud,
                              input logic sv, input logic [3:0] sd, input logic ordy,
                              input logic ur, input logic sr, input logic ov,
                              input logic [3:0] od, input logic osrc, input logic otr,
                              input logic cd, input int ug, input int sg,
                              input int ug2, input int sg2);
    vec_t v;
    v.rst = rst; v.uv = uv; v.ud = ud; v.sv = sv; v.sd = sd; v.ordy = ordy;
    v.ur = ur; v.sr = sr; v.ov = ov; v.od = od; v.osrc = osrc; v.otr = otr;
    v.cd = cd; v.ug = ug; v.sg = sg; v.ug2 = ug2; v.sg2 = sg2;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic uv, input logic [3:0] ud,
                       input logic sv, input logic [3:0] sd, input logic ordy);
    rst_n = rst; u_valid = uv; u_data = ud; s_valid = sv; s_data = sd; out_ready = ordy;
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    //           rst uv ud    sv sd    or  ur sr ov od    src tr cd ug sg ug2 sg2
    vecs.push_back(mk(0, 1, 4'hB, 1, 4'hB, 1, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'hB, 1, 4'hB, 1, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4'hB, 0, 4'h0, 1, 1, 0, 1, 4'h3, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 4'h0, 1, 4'hB, 1, 0, 1, 1, 4'hB, 1, 0, 1, 1, 1, 1, 1));
    // both valid, alternating grants U,S,U,S,U,S
    vecs.push_back(mk(1, 1, 4'h5, 1, 4'hA, 1, 1, 0, 1, 4'h5, 0, 0, 1, 2, 1, 2, 1));
    vecs.push_back(mk(1, 1, 4'h6, 1, 4'h9, 1, 0, 1, 1, 4'h9, 1, 0, 1, 2, 2, 2, 2));
    vecs.push_back(mk(1, 1, 4'hC, 1, 4'h1, 1, 1, 0, 1, 4'h4, 0, 1, 1, 3, 2, 3, 2));
    vecs.push_back(mk(1, 1, 4'h2, 1, 4'hF, 1, 0, 1, 1, 4'hF, 1, 0, 1, 3, 3, 3, 3));
    vecs.push_back(mk(1, 1, 4'h7, 1, 4'h3, 1, 1, 0, 1, 4'h7, 0, 0, 1, 4, 3, 3, 3));
    vecs.push_back(mk(1, 1, 4'h0, 1, 4'h8, 1, 0, 1, 1, 4'h8, 1, 0, 1, 4, 4, 3, 3));
    // stall with both valid: output held, nothing accepted
    vecs.push_back(mk(1, 1, 4'hD, 1, 4'h2, 0, 0, 0, 1, 4'h8, 1, 0, 1, 4, 4, 3, 3));
    vecs.push_back(mk(1, 1, 4'hD, 1, 4'h2, 0, 0, 0, 1, 4'h8, 1, 0, 1, 4, 4, 3, 3));
    vecs.push_back(mk(1, 1, 4'hD, 1, 4'h2, 0, 0, 0, 1, 4'h8, 1, 0, 1, 4, 4, 3, 3));
    vecs.push_back(mk(1, 1, 4'hD, 1, 4'h2, 1, 1, 0, 1, 4'h5, 0, 1, 1, 5, 4, 3, 3));
    // drain to EMPTY, then EMPTY accepts even with out_ready low
    vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 5, 4, 3, 3));
    vecs.push_back(mk(1, 0, 4'h0, 1, 4'h4, 0, 0, 1, 1, 4'h4, 1, 0, 1, 5, 5, 3, 3));
    vecs.push_back(mk(1, 1, 4'h3, 0, 4'h0, 0, 0, 0, 1, 4'h4, 1, 0, 1, 5, 5, 3, 3));
    // reset while FULL, then U wins first contention again
    vecs.push_back(mk(0, 1, 4'h3, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4'h1, 1, 4'hE, 1, 1, 0, 1, 4'h1, 0, 0, 1, 1, 0, 1, 0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].uv, vecs[i].ud, vecs[i].sv, vecs[i].sd, vecs[i].ordy);
      #1;
      chk("u_ready", i, int'(u_ready), int'(vecs[i].ur));
      chk("s_ready", i, int'(s_ready), int'(vecs[i].sr));
      @(posedge clk); #1;
      chk("out_valid", i, int'(out_valid), int'(vecs[i].ov));
      if (vecs[i].cd) begin
        chk("out_data", i, int'(od_u), int'(vecs[i].od));
        chk("out_src", i, int'(out_src), int'(vecs[i].osrc));
        chk("out_trunc", i, int'(out_trunc), int'(vecs[i].otr));
      end
      chk("u_grants", i, int'(u_grants), vecs[i].ug);
      chk("s_grants", i, int'(s_grants), vecs[i].sg);
      chk("u_grants_sat", i, int'(u_grants2), vecs[i].ug2);
      chk("s_grants_sat", i, int'(s_grants2), vecs[i].sg2);
      @(negedge clk);
    end

    // Five back-to-back U-only accepts: wide counter 1->6, narrow one pinned at 3.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 4'(k + 8), 1'b0, 4'h0, 1'b1);
      #1;
      chk("seq_u_ready", 100 + k, int'(u_ready), 1);
      @(posedge clk); #1;
      chk("seq_out_valid", 100 + k, int'(out_valid), 1);
      chk("seq_out_data", 100 + k, int'(od_u), k);
      chk("seq_out_trunc", 100 + k, int'(out_trunc), 1);
      @(negedge clk);
    end
    chk("seq_u_grants", 105, int'(u_grants), 6);
    chk("seq_u_grants_sat", 105, int'(u_grants2), 3);
    chk("seq_s_grants_sat", 105, int'(s_grants2), 0);

    // Reset while FULL with both sources valid: readys low during reset.
    drive(1'b0, 1'b1, 4'h1, 1'b1, 4'h1, 1'b0);
    #1;
    chk("rst_u_ready", 106, int'(u_ready), 0);
    chk("rst_s_ready", 106, int'(s_ready), 0);
    @(posedge clk); #1;
    chk("rst_out_valid", 106, int'(out_valid), 0);
    chk("rst_u_grants", 106, int'(u_grants), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
